// File: rtl/cmd_frame_rx_if.sv
// Bus between the SPI/Ethernet bridge side and cmd_frame_rx: word strobe, active-bank read port, status.
// Handshake: there is no ready. A rising edge on cs announces a new word. word_in must stay stable
// until the receiver has re-timed cs, which is at least SYNC_STAGES+2 clk cycles after the edge.
interface cmd_frame_rx_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic          cs;
  logic [DW-1:0] word_in;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [7:0]    word_cnt;
  logic          busy;
  logic          frame_ok;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [15:0]   frame_cnt;
  logic [1:0]    dbg_state;

  modport master (
    output cs, word_in, rd_addr,
    input  rd_data, word_cnt, busy, frame_ok, frame_err, err_code, frame_cnt, dbg_state
  );

  modport slave (
    input  cs, word_in, rd_addr,
    output rd_data, word_cnt, busy, frame_ok, frame_err, err_code, frame_cnt, dbg_state
  );
endinterface

// File: rtl/cmd_frame_rx.sv
// Command frame receiver: header, NREG payload words and an optional checksum fill a shadow bank,
// which is copied to the active bank only when the whole frame is good.
module cmd_frame_rx #(
  parameter int DW          = 16,
  parameter int NREG        = 50,
  parameter int CMD_HDR     = 17229,
  parameter int CHK_EN      = 1,
  parameter int RESYNC      = 1,
  parameter int TIMEOUT     = 50000,
  parameter int SYNC_STAGES = 2,
  parameter int AW          = (NREG > 1) ? $clog2(NREG) : 1
) (
  input logic           clk,
  input logic           rst,
  cmd_frame_rx_if.slave bus
);
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0]  HDR      = DW'(CMD_HDR);
  localparam logic [7:0]     LAST_IDX = 8'(NREG - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RECV = 2'd1, S_CHECK = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   cs_prev_q;
  logic                   strobe;
  logic [DW-1:0]          shadow_q [NREG];
  logic [DW-1:0]          shadow_d [NREG];
  logic [DW-1:0]          active_q [NREG];
  logic [DW-1:0]          sum_q;
  logic [7:0]             word_cnt_q;
  logic [TW-1:0]          tmr_q;
  logic                   frame_ok_q, frame_err_q;
  logic [1:0]             err_code_q, err_code_d;
  logic [15:0]            frame_cnt_q;
  logic                   is_hdr, is_last, sum_match, tmo;
  logic                   do_restart, do_store, do_commit, do_err;

  assign strobe    = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
  assign is_hdr    = (bus.word_in == HDR);
  assign is_last   = (word_cnt_q == LAST_IDX);
  assign sum_match = (bus.word_in == sum_q);
  assign tmo       = (tmr_q == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (strobe && is_hdr) state_d = S_RECV;
      S_RECV: begin
        if (strobe) begin
          if (!((RESYNC != 0) && is_hdr) && is_last) state_d = (CHK_EN != 0) ? S_CHECK : S_IDLE;
        end else if (tmo) begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: if (strobe || tmo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A strobe always takes priority over an expiring timer in the same cycle.
  always_comb begin
    do_restart = 1'b0;
    do_store   = 1'b0;
    do_commit  = 1'b0;
    do_err     = 1'b0;
    err_code_d = 2'd0;
    case (state_q)
      S_IDLE: do_restart = strobe && is_hdr;
      S_RECV: begin
        if (strobe) begin
          if ((RESYNC != 0) && is_hdr) begin
            do_restart = 1'b1;
            do_err     = 1'b1;
            err_code_d = 2'd3;
          end else begin
            do_store  = 1'b1;
            do_commit = is_last && (CHK_EN == 0);
          end
        end else if (tmo) begin
          do_err     = 1'b1;
          err_code_d = 2'd2;
        end
      end
      S_CHECK: begin
        if (strobe) begin
          if (sum_match) begin
            do_commit = 1'b1;
          end else begin
            do_err     = 1'b1;
            err_code_d = 2'd1;
          end
        end else if (tmo) begin
          do_err     = 1'b1;
          err_code_d = 2'd2;
        end
      end
      default: ;
    endcase
  end

  // Without a checksum the last payload word commits in the same edge it is stored, so the
  // active bank loads from the merged next-shadow value.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < NREG; i++) begin
      if (do_store && (word_cnt_q == 8'(i))) shadow_d[i] = bus.word_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '0;
      cs_prev_q   <= 1'b0;
      sum_q       <= '0;
      word_cnt_q  <= '0;
      tmr_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      frame_cnt_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      shadow_q    <= shadow_d;
      frame_ok_q  <= do_commit;
      frame_err_q <= do_err;
      if (do_err) err_code_q <= err_code_d;
      if (do_commit) begin
        active_q    <= shadow_d;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (do_restart) begin
        word_cnt_q <= '0;
        sum_q      <= '0;
      end else if (do_store) begin
        word_cnt_q <= word_cnt_q + 8'd1;
        sum_q      <= sum_q + bus.word_in;
      end
      if (strobe || (state_q == S_IDLE)) tmr_q <= '0;
      else                               tmr_q <= tmr_q + TW'(1);
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (bus.rd_addr == AW'(i)) bus.rd_data = active_q[i];
    end
  end

  assign bus.word_cnt  = word_cnt_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_cmd_frame_rx.sv
// Bench for cmd_frame_rx: two instances (checksum on / off) share one word stream; a frame-level
// reference model with per-frame payload arrays predicts pulses, counters and bank contents.
module tb_cmd_frame_rx;
  localparam int          NREG    = 4;
  localparam int          TIMEOUT = 100;
  localparam int          SYNC    = 2;
  localparam logic [15:0] HDR     = 16'h434D;

  logic clk, rst;
  int   cyc;
  int   last_rise;
  int   compared, mismatched;

  cmd_frame_rx_if #(.DW(16), .AW(2)) bus_a ();
  cmd_frame_rx_if #(.DW(16), .AW(2)) bus_b ();

  cmd_frame_rx #(.DW(16), .NREG(NREG), .CMD_HDR(17229), .CHK_EN(1), .RESYNC(1),
                 .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC), .AW(2))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  cmd_frame_rx #(.DW(16), .NREG(NREG), .CMD_HDR(17229), .CHK_EN(0), .RESYNC(1),
                 .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC), .AW(2))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model (index 0: checksum on, 1: checksum off) ----------------
  logic        m_in   [2];
  int          m_n    [2];
  logic [15:0] m_pl   [2][NREG];
  logic [15:0] m_act  [2][NREG];
  logic [15:0] m_fcnt [2];
  logic [1:0]  m_code [2];
  logic        exp_ok [2];
  logic        exp_err[2];
  logic [15:0] exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_in[c] = 1'b0; m_n[c] = 0; m_fcnt[c] = '0; m_code[c] = '0;
      exp_ok[c] = 1'b0; exp_err[c] = 1'b0;
      for (int i = 0; i < NREG; i++) begin
        m_pl[c][i] = '0; m_act[c][i] = '0;
      end
    end
  endtask

  function automatic logic [15:0] pl_sum(int c);
    logic [15:0] s = '0;
    for (int i = 0; i < m_n[c]; i++) s = s + m_pl[c][i];
    return s;
  endfunction

  task automatic model_commit(int c);
    for (int i = 0; i < NREG; i++) m_act[c][i] = m_pl[c][i];
    m_fcnt[c]++;
    exp_ok[c] = 1'b1;
    m_in[c]   = 1'b0;
  endtask

  task automatic model_word(int c, logic [15:0] w);
    bit chk = (c == 0);
    exp_ok[c]  = 1'b0;
    exp_err[c] = 1'b0;
    if (!m_in[c]) begin
      if (w == HDR) begin
        m_in[c] = 1'b1;
        m_n[c]  = 0;
      end
    end else if (m_n[c] < NREG) begin
      if (w == HDR) begin
        m_n[c] = 0; exp_err[c] = 1'b1; m_code[c] = 2'd3;
      end else begin
        m_pl[c][m_n[c]] = w;
        m_n[c]++;
        if (m_n[c] == NREG && !chk) model_commit(c);
      end
    end else begin
      if (w == pl_sum(c)) model_commit(c);
      else begin
        exp_err[c] = 1'b1; m_code[c] = 2'd1; m_in[c] = 1'b0;
      end
    end
  endtask

  task automatic model_timeout();
    for (int c = 0; c < 2; c++) begin
      if (m_in[c]) begin
        m_in[c] = 1'b0; m_code[c] = 2'd2;
      end
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_one(input string tag, input int c, input logic ok, input logic err,
                           input logic [1:0] code, input logic [7:0] wcnt,
                           input logic [15:0] fcnt, input logic busy);
    string s = (c == 0) ? "a" : "b";
    chk($sformatf("%s/%s frame_ok", tag, s), ok, exp_ok[c]);
    chk($sformatf("%s/%s frame_err", tag, s), err, exp_err[c]);
    chk($sformatf("%s/%s ok_err_excl", tag, s), ok & err, 1'b0);
    chk($sformatf("%s/%s err_code", tag, s), code, m_code[c]);
    chk($sformatf("%s/%s word_cnt", tag, s), wcnt, m_n[c]);
    chk($sformatf("%s/%s frame_cnt", tag, s), fcnt, m_fcnt[c]);
    chk($sformatf("%s/%s busy", tag, s), busy, m_in[c]);
  endtask

  task automatic check_model(input string tag);
    check_one(tag, 0, bus_a.frame_ok, bus_a.frame_err, bus_a.err_code, bus_a.word_cnt,
              bus_a.frame_cnt, bus_a.busy);
    check_one(tag, 1, bus_b.frame_ok, bus_b.frame_err, bus_b.err_code, bus_b.word_cnt,
              bus_b.frame_cnt, bus_b.busy);
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < NREG; a++) begin
      exp_q.push_back(m_act[0][a]);
      exp_q.push_back(m_act[1][a]);
    end
    for (int a = 0; a < NREG; a++) begin
      bus_a.rd_addr = 2'(a);
      bus_b.rd_addr = 2'(a);
      #1;
      chk($sformatf("%s rd_a[%0d]", tag, a), bus_a.rd_data, exp_q.pop_front());
      chk($sformatf("%s rd_b[%0d]", tag, a), bus_b.rd_data, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Leaves cs high and returns on the negedge just after the strobe has been acted on.
  task automatic strobe_word(input logic [15:0] w, input int gap);
    while (cyc - last_rise < gap) @(negedge clk);
    bus_a.word_in = w; bus_b.word_in = w;
    bus_a.cs = 1'b1;   bus_b.cs = 1'b1;
    last_rise = cyc;
    model_word(0, w);
    model_word(1, w);
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic release_word();
    bus_a.cs = 1'b0; bus_b.cs = 1'b0;
    @(negedge clk);
    chk("pulse_len a", {bus_a.frame_ok, bus_a.frame_err}, 2'b00);
    chk("pulse_len b", {bus_b.frame_ok, bus_b.frame_err}, 2'b00);
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] w, input int gap, input string tag);
    strobe_word(w, gap);
    check_model(tag);
    release_word();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] v = 16'($urandom_range(0, 16'hFFFF));
    if (v == HDR) v = 16'h0000;
    return v;
  endfunction

  // ---------------- vector table (checksum-on instance, rd_addr = 2) ----------------
  typedef struct {
    logic [15:0] w;
    logic        ok;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  wcnt;
    logic        busy;
    logic [15:0] fcnt;
    logic [15:0] rd2;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t v(logic [15:0] w, logic ok, logic err, logic [1:0] code,
                             logic [7:0] wcnt, logic busy, logic [15:0] fcnt, logic [15:0] rd2);
    vec_t r;
    r.w = w; r.ok = ok; r.err = err; r.code = code;
    r.wcnt = wcnt; r.busy = busy; r.fcnt = fcnt; r.rd2 = rd2;
    return r;
  endfunction

  // ---------------- main test ----------------
  initial begin
    logic [15:0] fw[$];
    logic [15:0] s;
    int ta, tb;
    int kind;

    compared = 0; mismatched = 0;
    model_reset();

    // good frame
    tbl[0]  = v(HDR,     0, 0, 0, 0, 1, 0, 0);
    tbl[1]  = v(16'd1,   0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = v(16'd2,   0, 0, 0, 2, 1, 0, 0);
    tbl[3]  = v(16'd3,   0, 0, 0, 3, 1, 0, 0);
    tbl[4]  = v(16'd4,   0, 0, 0, 4, 1, 0, 0);
    tbl[5]  = v(16'h000A, 1, 0, 0, 4, 0, 1, 3);
    // bad checksum
    tbl[6]  = v(HDR,     0, 0, 0, 0, 1, 1, 3);
    tbl[7]  = v(16'd1,   0, 0, 0, 1, 1, 1, 3);
    tbl[8]  = v(16'd2,   0, 0, 0, 2, 1, 1, 3);
    tbl[9]  = v(16'd3,   0, 0, 0, 3, 1, 1, 3);
    tbl[10] = v(16'd4,   0, 0, 0, 4, 1, 1, 3);
    tbl[11] = v(16'h000B, 0, 1, 1, 4, 0, 1, 3);
    // junk outside a frame
    tbl[12] = v(16'h1234, 0, 0, 1, 4, 0, 1, 3);
    tbl[13] = v(16'h0001, 0, 0, 1, 4, 0, 1, 3);
    // resync on a second header
    tbl[14] = v(HDR,     0, 0, 1, 0, 1, 1, 3);
    tbl[15] = v(16'd1,   0, 0, 1, 1, 1, 1, 3);
    tbl[16] = v(HDR,     0, 1, 3, 0, 1, 1, 3);
    tbl[17] = v(16'd5,   0, 0, 3, 1, 1, 1, 3);
    tbl[18] = v(16'd6,   0, 0, 3, 2, 1, 1, 3);
    tbl[19] = v(16'd7,   0, 0, 3, 3, 1, 1, 3);
    tbl[20] = v(16'd8,   0, 0, 3, 4, 1, 1, 3);
    tbl[21] = v(16'h001A, 1, 0, 3, 4, 0, 2, 7);

    rst = 1'b1;
    bus_a.cs = 1'b0; bus_b.cs = 1'b0;
    bus_a.word_in = '0; bus_b.word_in = '0;
    bus_a.rd_addr = '0; bus_b.rd_addr = '0;
    repeat (2) @(negedge clk);
    check_model("reset");
    readback("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    last_rise = cyc;

    // table-driven directed vectors
    bus_a.rd_addr = 2'd2; bus_b.rd_addr = 2'd2;
    for (int i = 0; i < 22; i++) begin
      strobe_word(tbl[i].w, 0);
      chk($sformatf("tbl[%0d] frame_ok", i), bus_a.frame_ok, tbl[i].ok);
      chk($sformatf("tbl[%0d] frame_err", i), bus_a.frame_err, tbl[i].err);
      chk($sformatf("tbl[%0d] err_code", i), bus_a.err_code, tbl[i].code);
      chk($sformatf("tbl[%0d] word_cnt", i), bus_a.word_cnt, tbl[i].wcnt);
      chk($sformatf("tbl[%0d] busy", i), bus_a.busy, tbl[i].busy);
      chk($sformatf("tbl[%0d] frame_cnt", i), bus_a.frame_cnt, tbl[i].fcnt);
      chk($sformatf("tbl[%0d] rd_data@2", i), bus_a.rd_data, tbl[i].rd2);
      check_model($sformatf("tbl[%0d]", i));
      release_word();
    end
    readback("after_table");

    // a strobe landing exactly on the timeout cycle must win
    send(HDR, 0, "race_hdr");
    send(16'd1, 0, "race_w1");
    send(16'd2, TIMEOUT, "race_w2");
    send(16'd3, 0, "race_w3");
    send(16'd4, 0, "race_w4");
    send(16'h000A, 0, "race_chk");

    // timeout: error one TIMEOUT after the last strobe is acted on
    send(HDR, 0, "tmo_hdr");
    send(16'd1, 0, "tmo_w1");
    send(16'd2, 0, "tmo_w2");
    ta = -1; tb = -1;
    for (int n = 0; n < 400 && (ta < 0 || tb < 0); n++) begin
      @(negedge clk);
      if (bus_a.frame_err && ta < 0) ta = cyc - last_rise;
      if (bus_b.frame_err && tb < 0) tb = cyc - last_rise;
    end
    chk("tmo_cycle a", ta, TIMEOUT + SYNC + 1);
    chk("tmo_cycle b", tb, TIMEOUT + SYNC + 1);
    model_timeout();
    chk("tmo err_code a", bus_a.err_code, m_code[0]);
    chk("tmo err_code b", bus_b.err_code, m_code[1]);
    chk("tmo busy a", bus_a.busy, 1'b0);
    chk("tmo busy b", bus_b.busy, 1'b0);
    chk("tmo word_cnt a", bus_a.word_cnt, 8'd2);
    @(negedge clk);
    readback("after_tmo");

    // randomized frames against the model
    for (int f = 0; f < 20; f++) begin
      fw.delete();
      kind = $urandom_range(0, 3);
      if (kind == 2) fw.push_back(rand_word());
      fw.push_back(HDR);
      if (kind == 3) begin
        for (int k = 0, n = $urandom_range(0, 3); k < n; k++) fw.push_back(rand_word());
        fw.push_back(HDR);
      end
      s = '0;
      for (int k = 0; k < NREG; k++) begin
        logic [15:0] p = rand_word();
        fw.push_back(p);
        s = s + p;
      end
      fw.push_back((kind == 1) ? s + 16'd1 : s);
      foreach (fw[i]) send(fw[i], 0, $sformatf("rnd%0d.%0d", f, i));
    end
    readback("after_random");

    // reset in the middle of a frame
    send(HDR, 0, "mid_hdr");
    send(16'd5, 0, "mid_w1");
    send(16'd6, 0, "mid_w2");
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_model("mid_rst");
    readback("mid_rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    last_rise = cyc;
    send(HDR, 0, "post_hdr");
    send(16'd1, 0, "post_w1");
    send(16'd2, 0, "post_w2");
    send(16'd3, 0, "post_w3");
    send(16'd4, 0, "post_w4");
    send(16'h000A, 0, "post_chk");
    readback("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
